dic_ctrl_fsm_p: RTL and testbench

DIC_CTRL_FSM_P -- requirements
Module: dic_ctrl_fsm_p

---
 rtl/dic_pkg.sv | 17 +
 rtl/dic_ctrl_fsm_p_if.sv | 41 ++++
 rtl/dic_digit_check.sv | 32 +++
 rtl/dic_ctrl_fsm_p.sv | 146 ++++++++++++++
 tb/tb_dic_ctrl_fsm_p.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dic_pkg.sv
// rtl/dic_pkg.sv - shared state encoding and digit-range constants for the clock/alarm entry controller
package dic_pkg;

  typedef enum logic [2:0] {
    ST_STOP    = 3'd0,
    ST_RUN     = 3'd1,
    ST_SEL_ALM = 3'd2,
    ST_LOAD    = 3'd3,
    ST_WAIT    = 3'd4
  } dic_state_t;

  // An odd digit index is a tens position (0-5); hours are further limited to 23.
  localparam logic       TENS_POS             = 1'b1;
  localparam logic [3:0] HOUR_TENS_MAX        = 4'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_20 = 4'd3;

endpackage

// File: rtl/dic_ctrl_fsm_p_if.sv
// rtl/dic_ctrl_fsm_p_if.sv - key-decoder inputs and load/display controls of the entry controller
interface dic_ctrl_fsm_p_if #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_ALARMS = 2
);
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  det_num;
  logic                  det_num0to5;
  logic [3:0]            num_val;
  logic                  det_cr;
  logic                  det_atSign;
  logic                  det_A;
  logic                  det_L;
  logic                  det_S;
  logic                  det_bs;
  logic                  key_vld;

  logic                  dic_run;
  logic                  ld_time;
  logic                  ld_alarm;
  logic [AW-1:0]         alarm_sel;
  logic [NUM_ALARMS-1:0] alarm_ena;
  logic [NUM_DIGITS-1:0] ld_digit;
  logic [NUM_DIGITS-1:0] dsp_time_mask;
  logic [NUM_DIGITS-1:0] dsp_alarm_mask;
  logic                  valid_num;
  logic                  load_done;

  modport master (
    output det_num, det_num0to5, num_val, det_cr, det_atSign, det_A, det_L, det_S, det_bs, key_vld,
    input  dic_run, ld_time, ld_alarm, alarm_sel, alarm_ena, ld_digit,
           dsp_time_mask, dsp_alarm_mask, valid_num, load_done
  );

  modport slave (
    input  det_num, det_num0to5, num_val, det_cr, det_atSign, det_A, det_L, det_S, det_bs, key_vld,
    output dic_run, ld_time, ld_alarm, alarm_sel, alarm_ena, ld_digit,
           dsp_time_mask, dsp_alarm_mask, valid_num, load_done
  );
endinterface

// File: rtl/dic_digit_check.sv
// rtl/dic_digit_check.sv - decides whether the pressed key is a legal digit for the current position
module dic_digit_check
  import dic_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic [IW-1:0] i_idx,
  input  logic [3:0]    i_num_val,
  input  logic          i_det_num,
  input  logic          i_det_num0to5,
  input  logic          i_hour_tens_two,
  output logic          o_ok
);

  logic w_class_ok;
  logic w_range_ok;

  always_comb begin
    w_class_ok = (i_idx[0] == TENS_POS) ? i_det_num0to5 : i_det_num;
    w_range_ok = 1'b1;
    if (NUM_DIGITS == 6) begin
      if (i_idx == IW'(5))
        w_range_ok = (i_num_val <= HOUR_TENS_MAX);
      else if ((i_idx == IW'(4)) && i_hour_tens_two)
        w_range_ok = (i_num_val <= HOUR_UNITS_MAX_AT_20);
    end
  end

  assign o_ok = w_class_ok & w_range_ok;

endmodule

// File: rtl/dic_ctrl_fsm_p.sv
// rtl/dic_ctrl_fsm_p.sv - run/stop and time/alarm digit-entry controller for a digital clock
module dic_ctrl_fsm_p
  import dic_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_ALARMS = 2,
  parameter int TIMEOUT    = 1000
) (
  input logic             clk,
  input logic             rst,
  dic_ctrl_fsm_p_if.slave bus
);

  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(NUM_DIGITS - 1);
  localparam logic [3:0]    ALM_MAX = 4'(NUM_ALARMS);
  localparam logic [NUM_DIGITS-1:0] ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  dic_state_t            r_state;
  logic [IW-1:0]         r_idx;
  logic [AW-1:0]         r_alarm_sel;
  logic [NUM_ALARMS-1:0] r_alarm_ena;
  logic [CW-1:0]         r_idle;
  logic                  r_load_done;
  logic                  r_saved_run;
  logic                  r_mode_alarm;
  logic                  r_hour_two;

  logic                  w_ok;
  logic                  w_valid;
  logic                  w_in_entry;
  logic                  w_timeout;
  logic                  w_alm_key_ok;
  logic                  w_sel_ena;
  logic                  w_load_time;
  logic                  w_load_alarm;
  logic [NUM_DIGITS-1:0] w_entry_mask;

  dic_digit_check #(.NUM_DIGITS(NUM_DIGITS), .IW(IW)) u_digit_check (
    .i_idx          (r_idx),
    .i_num_val      (bus.num_val),
    .i_det_num      (bus.det_num),
    .i_det_num0to5  (bus.det_num0to5),
    .i_hour_tens_two(r_hour_two),
    .o_ok           (w_ok)
  );

  assign w_in_entry   = (r_state == ST_SEL_ALM) || (r_state == ST_LOAD) || (r_state == ST_WAIT);
  assign w_timeout    = w_in_entry && !bus.key_vld && (r_idle == CW'(TIMEOUT - 1));
  // Gated by rst so a key landing in the reset cycle never loads a digit.
  assign w_valid      = (r_state == ST_LOAD) && w_ok && !rst;
  assign w_alm_key_ok = bus.det_num && (bus.num_val >= 4'd1) && (bus.num_val <= ALM_MAX);
  assign w_sel_ena    = r_alarm_ena[r_alarm_sel];
  assign w_load_time  = (r_state == ST_LOAD) && !r_mode_alarm;
  assign w_load_alarm = (r_state == ST_LOAD) && r_mode_alarm;
  assign w_entry_mask = ~((ONE << r_idx) - ONE);

  assign bus.valid_num      = w_valid;
  assign bus.ld_digit       = w_valid ? (ONE << r_idx) : '0;
  assign bus.ld_time        = w_load_time;
  assign bus.ld_alarm       = w_load_alarm;
  assign bus.dsp_time_mask  = w_load_time ? w_entry_mask : '1;
  assign bus.dsp_alarm_mask = w_load_alarm ? w_entry_mask : {NUM_DIGITS{w_sel_ena}};
  assign bus.dic_run        = (r_state == ST_RUN) || (w_in_entry && r_mode_alarm && r_saved_run);
  assign bus.alarm_sel      = r_alarm_sel;
  assign bus.alarm_ena      = r_alarm_ena;
  assign bus.load_done      = r_load_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_STOP;
      r_idx        <= IDX_TOP;
      r_alarm_sel  <= '0;
      r_alarm_ena  <= '0;
      r_idle       <= '0;
      r_load_done  <= 1'b0;
      r_saved_run  <= 1'b0;
      r_mode_alarm <= 1'b0;
      r_hour_two   <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      if (bus.det_atSign)
        r_alarm_ena[r_alarm_sel] <= ~r_alarm_ena[r_alarm_sel];
      r_idle <= (bus.key_vld || !w_in_entry) ? '0 : r_idle + 1'b1;

      if (w_timeout) begin
        r_state <= r_saved_run ? ST_RUN : ST_STOP;
      end else begin
        unique case (r_state)
          ST_STOP, ST_RUN: begin
            if (bus.det_cr) begin
              r_state <= ST_STOP;
            end else if (bus.det_S) begin
              r_state <= ST_RUN;
            end else if (bus.det_L) begin
              r_state      <= ST_LOAD;
              r_mode_alarm <= 1'b0;
              r_idx        <= IDX_TOP;
              r_hour_two   <= 1'b0;
              r_saved_run  <= (r_state == ST_RUN);
            end else if (bus.det_A) begin
              r_state      <= ST_SEL_ALM;
              r_mode_alarm <= 1'b1;
              r_saved_run  <= (r_state == ST_RUN);
            end
          end
          ST_SEL_ALM: begin
            if (w_alm_key_ok) begin
              r_alarm_sel <= AW'(bus.num_val - 4'd1);
              r_state     <= ST_LOAD;
              r_idx       <= IDX_TOP;
              r_hour_two  <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (w_valid) begin
              if (r_idx == IDX_TOP)
                r_hour_two <= (bus.num_val == HOUR_TENS_MAX);
              if (r_idx == '0) begin
                r_state     <= ST_WAIT;
                r_load_done <= 1'b1;
              end else begin
                r_idx <= r_idx - 1'b1;
              end
            end else if (bus.det_bs) begin
              if (r_idx == IDX_TOP)
                r_state <= r_saved_run ? ST_RUN : ST_STOP;
              else
                r_idx <= r_idx + 1'b1;
            end
          end
          ST_WAIT: begin
            if (bus.det_cr)
              r_state <= ST_STOP;
            else if (bus.det_S)
              r_state <= ST_RUN;
          end
          default: r_state <= ST_STOP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dic_ctrl_fsm_p.sv
// tb/tb_dic_ctrl_fsm_p.sv - scoreboard bench for dic_ctrl_fsm_p with 4- and 6-digit instances
module tb_dic_ctrl_fsm_p;

  typedef struct packed {
    logic       det_num;
    logic       det_num0to5;
    logic [3:0] num_val;
    logic       det_cr;
    logic       det_atSign;
    logic       det_A;
    logic       det_L;
    logic       det_S;
    logic       det_bs;
    logic       key_vld;
  } key_t;

  typedef struct {
    string       nm;
    int          f;
    logic [31:0] exp;
  } sts_t;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } ev_t;

  localparam int F_RUN4 = 0, F_LDT4 = 1, F_LDA4 = 2, F_SEL4 = 3, F_ENA4 = 4, F_TM4 = 5,
                 F_AM4 = 6, F_VN4 = 7, F_DONE4 = 8, F_LDT6 = 9, F_TM6 = 10, F_VN6 = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  key_t k4 = '0;
  key_t k6 = '0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  sts_t stsq[$];
  ev_t  ldq4[$];
  ev_t  ldq6[$];
  ev_t  dq4[$];
  ev_t  dq6[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dic_ctrl_fsm_p_if #(.NUM_DIGITS(4), .NUM_ALARMS(2)) b4 ();
  dic_ctrl_fsm_p_if #(.NUM_DIGITS(6), .NUM_ALARMS(2)) b6 ();

  assign b4.det_num = k4.det_num;   assign b4.det_num0to5 = k4.det_num0to5;
  assign b4.num_val = k4.num_val;   assign b4.det_cr      = k4.det_cr;
  assign b4.det_atSign = k4.det_atSign; assign b4.det_A   = k4.det_A;
  assign b4.det_L   = k4.det_L;     assign b4.det_S       = k4.det_S;
  assign b4.det_bs  = k4.det_bs;    assign b4.key_vld     = k4.key_vld;
  assign b6.det_num = k6.det_num;   assign b6.det_num0to5 = k6.det_num0to5;
  assign b6.num_val = k6.num_val;   assign b6.det_cr      = k6.det_cr;
  assign b6.det_atSign = k6.det_atSign; assign b6.det_A   = k6.det_A;
  assign b6.det_L   = k6.det_L;     assign b6.det_S       = k6.det_S;
  assign b6.det_bs  = k6.det_bs;    assign b6.key_vld     = k6.key_vld;

  dic_ctrl_fsm_p #(.NUM_DIGITS(4), .NUM_ALARMS(2), .TIMEOUT(16)) dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave)
  );
  dic_ctrl_fsm_p #(.NUM_DIGITS(6), .NUM_ALARMS(2), .TIMEOUT(64)) dut6 (
    .clk(clk), .rst(rst), .bus(b6.slave)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fld(input int f);
    case (f)
      F_RUN4:  return 32'(b4.dic_run);
      F_LDT4:  return 32'(b4.ld_time);
      F_LDA4:  return 32'(b4.ld_alarm);
      F_SEL4:  return 32'(b4.alarm_sel);
      F_ENA4:  return 32'(b4.alarm_ena);
      F_TM4:   return 32'(b4.dsp_time_mask);
      F_AM4:   return 32'(b4.dsp_alarm_mask);
      F_VN4:   return 32'(b4.valid_num);
      F_DONE4: return 32'(b4.load_done);
      F_LDT6:  return 32'(b6.ld_time);
      F_TM6:   return 32'(b6.dsp_time_mask);
      F_VN6:   return 32'(b6.valid_num);
      default: return 32'hdead_beef;
    endcase
  endfunction

  function automatic key_t mk(input byte c, input bit at);
    key_t k;
    k = '0;
    k.key_vld    = 1'b1;
    k.det_atSign = at;
    if (c >= 8'h30 && c <= 8'h39) begin
      k.det_num     = 1'b1;
      k.num_val     = 4'(c - 8'h30);
      k.det_num0to5 = (c <= 8'h35);
    end
    case (c)
      "C": k.det_cr = 1'b1;
      "@": k.det_atSign = 1'b1;
      "A": k.det_A = 1'b1;
      "L": k.det_L = 1'b1;
      "S": k.det_S = 1'b1;
      "B": k.det_bs = 1'b1;
      "X": begin k.det_cr = 1'b1; k.det_S = 1'b1; end
      "Y": begin k.det_S = 1'b1;  k.det_L = 1'b1; end
      "Z": begin k.det_L = 1'b1;  k.det_A = 1'b1; end
      default: ;
    endcase
    return k;
  endfunction

  task automatic expect_sts(input string nm, input int f, input logic [31:0] exp);
    sts_t s;
    s.nm = nm; s.f = f; s.exp = exp;
    stsq.push_back(s);
  endtask

  task automatic expect_ld(input int d, input string nm, input logic [31:0] exp);
    ev_t e;
    e.nm = nm; e.exp = exp;
    if (d == 4) ldq4.push_back(e); else ldq6.push_back(e);
  endtask

  // load_done is expected one cycle after the final digit is accepted
  task automatic expect_done(input int d, input string nm);
    ev_t e;
    e.nm = nm; e.exp = 32'(cyc + 1);
    if (d == 4) dq4.push_back(e); else dq6.push_back(e);
  endtask

  task automatic key(input int d, input byte c, input bit at = 1'b0, input bit with_rst = 1'b0);
    if (d == 4) k4 = mk(c, at); else k6 = mk(c, at);
    if (with_rst) rst = 1'b1;
    @(posedge clk); #1;
    k4 = '0; k6 = '0; rst = 1'b0;
  endtask

  always @(negedge clk) begin
    sts_t s;
    ev_t  e;
    while (stsq.size() > 0) begin
      s = stsq.pop_front();
      cmp(s.nm, fld(s.f), s.exp);
    end
    if (b4.ld_digit != '0) begin
      if (ldq4.size() == 0) cmp("ld4_unexpected", 32'(b4.ld_digit), 32'h0);
      else begin e = ldq4.pop_front(); cmp(e.nm, 32'(b4.ld_digit), e.exp); end
    end
    if (b6.ld_digit != '0) begin
      if (ldq6.size() == 0) cmp("ld6_unexpected", 32'(b6.ld_digit), 32'h0);
      else begin e = ldq6.pop_front(); cmp(e.nm, 32'(b6.ld_digit), e.exp); end
    end
    if (b4.load_done) begin
      if (dq4.size() == 0) cmp("done4_unexpected_cycle", 32'(cyc), 32'hffff_ffff);
      else begin e = dq4.pop_front(); cmp(e.nm, 32'(cyc), e.exp); end
    end
    if (b6.load_done) begin
      if (dq6.size() == 0) cmp("done6_unexpected_cycle", 32'(cyc), 32'hffff_ffff);
      else begin e = dq6.pop_front(); cmp(e.nm, 32'(cyc), e.exp); end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    expect_sts("rst_run", F_RUN4, 0);   expect_sts("rst_ena", F_ENA4, 0);
    expect_sts("rst_sel", F_SEL4, 0);   expect_sts("rst_ldt", F_LDT4, 0);
    expect_sts("rst_done", F_DONE4, 0); expect_sts("rst_tm", F_TM4, 4'hf);
    expect_sts("rst_am", F_AM4, 0);     expect_sts("rst_vn", F_VN4, 0);
    @(posedge clk); #1;

    // six-digit hour rules
    key(6, "L");  expect_sts("d6_ldt", F_LDT6, 1); expect_sts("d6_tm_top", F_TM6, 6'b100000);
    expect_ld(6, "d6_ld5", 6'b100000); key(6, "2");
    expect_sts("d6_rej4_after2", F_VN6, 0); key(6, "4");
    expect_ld(6, "d6_ld4", 6'b010000); key(6, "3");
    expect_sts("d6_tm_two", F_TM6, 6'b111000);
    expect_sts("d6_rej6_tens", F_VN6, 0); key(6, "6");
    expect_ld(6, "d6_ld3", 6'b001000); key(6, "5");
    expect_ld(6, "d6_ld2", 6'b000100); key(6, "9");
    expect_ld(6, "d6_ld1", 6'b000010); key(6, "5");
    expect_ld(6, "d6_ld0", 6'b000001); expect_done(6, "d6_done_cycle"); key(6, "9");
    expect_sts("d6_wait_ldt", F_LDT6, 0);
    key(6, "C"); key(6, "L");
    expect_sts("d6_rej3_hour_tens", F_VN6, 0); key(6, "3");
    expect_ld(6, "d6_ld5_b", 6'b100000); key(6, "1");
    expect_ld(6, "d6_ld4_7_ok", 6'b010000); key(6, "7");
    key(6, "B"); key(6, "B"); key(6, "B");
    expect_sts("d6_bs_exit", F_LDT6, 0);

    // run and four-digit time load from RUN
    key(4, "S"); expect_sts("s_run", F_RUN4, 1); expect_sts("s_ena", F_ENA4, 0);
    key(4, "L"); expect_sts("l_ldt", F_LDT4, 1); expect_sts("l_halt", F_RUN4, 0);
    expect_sts("l_tm", F_TM4, 4'b1000);
    expect_sts("rej6_idx3", F_VN4, 0); key(4, "6");
    expect_ld(4, "ld3", 4'b1000); key(4, "5");
    expect_sts("tm_1100", F_TM4, 4'b1100);
    expect_ld(4, "ld2", 4'b0100); key(4, "9");
    expect_ld(4, "ld1", 4'b0010); key(4, "5");
    expect_ld(4, "ld0", 4'b0001); expect_done(4, "done_cycle"); key(4, "9");
    expect_sts("wait_ldt", F_LDT4, 0); expect_sts("wait_halt", F_RUN4, 0);
    key(4, "S"); expect_sts("wait_s_run", F_RUN4, 1);

    // backspace back out to saved STOP
    key(4, "C"); key(4, "L");
    expect_ld(4, "bs_ld3", 4'b1000); key(4, "1");
    key(4, "B"); expect_sts("bs_tm", F_TM4, 4'b1000); expect_sts("bs_ldt", F_LDT4, 1);
    key(4, "B"); expect_sts("bs_exit_ldt", F_LDT4, 0); expect_sts("bs_exit_stop", F_RUN4, 0);

    // alarm selection and enable toggle
    key(4, "A"); expect_sts("sel_lda", F_LDA4, 0);
    key(4, "2"); expect_sts("a2_lda", F_LDA4, 1); expect_sts("a2_sel", F_SEL4, 1);
    expect_sts("a2_am", F_AM4, 4'b1000); expect_sts("a2_tm", F_TM4, 4'hf);
    key(4, "@"); expect_sts("at_ena", F_ENA4, 2'b10);
    key(4, "B"); expect_sts("stop_am", F_AM4, 4'hf);
    key(4, "A"); key(4, "3");
    expect_sts("a3_lda", F_LDA4, 0); expect_sts("a3_sel", F_SEL4, 1);
    key(4, "1"); expect_sts("a1_lda", F_LDA4, 1); expect_sts("a1_sel", F_SEL4, 0);
    key(4, "@"); expect_sts("at0_ena", F_ENA4, 2'b11);
    key(4, "B");

    // @ together with a state-changing key, then key priorities
    key(4, "S", 1'b1); expect_sts("s_at_run", F_RUN4, 1); expect_sts("s_at_ena", F_ENA4, 2'b10);
    key(4, "X"); expect_sts("cr_over_s", F_RUN4, 0);
    key(4, "Y"); expect_sts("s_over_l_run", F_RUN4, 1); expect_sts("s_over_l_ldt", F_LDT4, 0);
    key(4, "Z"); expect_sts("l_over_a_ldt", F_LDT4, 1); expect_sts("l_over_a_lda", F_LDA4, 0);
    key(4, "B"); expect_sts("bs_back_run", F_RUN4, 1);

    // idle timeout returns to RUN without load_done
    key(4, "L");
    repeat (15) @(posedge clk);
    #1 expect_sts("to_15_still_load", F_LDT4, 1);
    @(posedge clk); #1;
    expect_sts("to_16_ldt", F_LDT4, 0); expect_sts("to_16_run", F_RUN4, 1);
    @(posedge clk); #1;

    // reset in the middle of an entry
    key(4, "L");
    expect_sts("rst_mid_vn", F_VN4, 0); key(4, "5", 1'b0, 1'b1);
    expect_sts("rst_mid_ldt", F_LDT4, 0); expect_sts("rst_mid_run", F_RUN4, 0);
    expect_sts("rst_mid_ena", F_ENA4, 0); expect_sts("rst_mid_sel", F_SEL4, 0);

    repeat (3) @(posedge clk);
    #1;
    cmp("ldq4_left", 32'(ldq4.size()), 0); cmp("ldq6_left", 32'(ldq6.size()), 0);
    cmp("dq4_left", 32'(dq4.size()), 0);   cmp("dq6_left", 32'(dq6.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
